// File: rtl/t02_wishbone_subordinate.sv
// Wishbone classic-cycle subordinate: a DEPTH-word, byte-writable register window at BASE_ADDR.
// Each accepted request is answered with a single-cycle ACK after WAIT_STATES wait cycles.
module t02_wishbone_subordinate #(
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int          DEPTH       = 16,
  parameter int          WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        en,
  input  logic [31:0] ADR_I,
  input  logic [31:0] DAT_I,
  input  logic [3:0]  SEL_I,
  input  logic        WE_I,
  input  logic        STB_I,
  input  logic        CYC_I,
  output logic [31:0] DAT_O,
  output logic        ACK_O,
  output logic [31:0] word0_o
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [31:0] WIN_MASK  = 32'(DEPTH * 4 - 1);
  localparam bit          NO_WAIT   = (WAIT_STATES == 0);
  localparam logic [3:0]  WAIT_LOAD = NO_WAIT ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, ACK, TURN} state_t;

  state_t        state;
  logic [3:0]    wait_cnt;
  logic [AW-1:0] lat_idx;
  logic [31:0]   lat_dat;
  logic [3:0]    lat_sel;
  logic          lat_we;
  logic [31:0]   mem [DEPTH];

  logic          hit;
  logic [AW-1:0] req_idx;

  logic          commit;
  logic [AW-1:0] c_idx;
  logic [31:0]   c_dat;
  logic [3:0]    c_sel;
  logic          c_we;

  assign hit     = CYC_I & STB_I & ((ADR_I & ~WIN_MASK) == BASE_ADDR);
  assign req_idx = ADR_I[2 +: AW];
  assign word0_o = mem[0];

  // The access is committed on the edge that enters ACK; with no wait states that is
  // the accepting edge itself, so the live bus fields are used instead of the latches.
  always_comb begin
    commit = 1'b0;
    c_idx  = lat_idx;
    c_dat  = lat_dat;
    c_sel  = lat_sel;
    c_we   = lat_we;
    case (state)
      IDLE: begin
        if (NO_WAIT && en && hit) begin
          commit = 1'b1;
          c_idx  = req_idx;
          c_dat  = DAT_I;
          c_sel  = SEL_I;
          c_we   = WE_I;
        end
      end
      WAIT: begin
        if (CYC_I && wait_cnt == 4'd0) commit = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state    <= IDLE;
      wait_cnt <= '0;
      lat_idx  <= '0;
      lat_dat  <= '0;
      lat_sel  <= '0;
      lat_we   <= 1'b0;
      ACK_O    <= 1'b0;
      DAT_O    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      ACK_O <= 1'b0;
      DAT_O <= '0;

      case (state)
        IDLE: begin
          if (en && hit) begin
            lat_idx <= req_idx;
            lat_dat <= DAT_I;
            lat_sel <= SEL_I;
            lat_we  <= WE_I;
            if (NO_WAIT) begin
              state <= ACK;
            end else begin
              wait_cnt <= WAIT_LOAD;
              state    <= WAIT;
            end
          end
        end
        WAIT: begin
          // Only the manager abandoning the cycle aborts; en is not consulted here.
          if (!CYC_I)                 state    <= IDLE;
          else if (wait_cnt == 4'd0)  state    <= ACK;
          else                        wait_cnt <= wait_cnt - 4'd1;
        end
        ACK:     state <= TURN;
        TURN:    state <= IDLE;
        default: state <= IDLE;
      endcase

      if (commit) begin
        ACK_O <= 1'b1;
        if (c_we) begin
          for (int b = 0; b < 4; b++)
            if (c_sel[b]) mem[c_idx][8*b +: 8] <= c_dat[8*b +: 8];
        end else begin
          DAT_O <= mem[c_idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_t02_wishbone_subordinate.sv
// Directed, table-driven bench for t02_wishbone_subordinate (main instance WAIT_STATES=1,
// a second WAIT_STATES=0 instance on the same bus for the back-to-back spacing check).
module tb_t02_wishbone_subordinate;

  localparam int WS = 1;

  logic        clk = 1'b0;
  logic        nrst, en;
  logic [31:0] adr, dat;
  logic [3:0]  sel;
  logic        we, stb, cyc;
  logic [31:0] dat_o, word0;
  logic        ack;
  logic [31:0] dat_o0, word0_0;
  logic        ack0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  t02_wishbone_subordinate #(.BASE_ADDR(32'h3000_0000), .DEPTH(16), .WAIT_STATES(WS)) dut (
    .clk(clk), .nrst(nrst), .en(en), .ADR_I(adr), .DAT_I(dat), .SEL_I(sel), .WE_I(we),
    .STB_I(stb), .CYC_I(cyc), .DAT_O(dat_o), .ACK_O(ack), .word0_o(word0));

  t02_wishbone_subordinate #(.BASE_ADDR(32'h3000_0000), .DEPTH(16), .WAIT_STATES(0)) dut0 (
    .clk(clk), .nrst(nrst), .en(en), .ADR_I(adr), .DAT_I(dat), .SEL_I(sel), .WE_I(we),
    .STB_I(stb), .CYC_I(cyc), .DAT_O(dat_o0), .ACK_O(ack0), .word0_o(word0_0));

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] exp_rd;
    logic [31:0] exp_w0;
  } vec_t;

  vec_t vecs [10];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction on the WS=1 instance; bus fields are scrambled after acceptance.
  task automatic applyStimulus(input vec_t v);
    int n;
    bit got;
    adr = v.adr; dat = v.dat; sel = v.sel; we = v.we; cyc = 1'b1; stb = 1'b1;
    n = 0;
    got = 1'b0;
    while (!got && n < 10) begin
      tick();
      n++;
      if (ack) got = 1'b1;
      if (n == 1) begin
        adr = adr ^ 32'h4; dat = ~dat; sel = ~sel;
      end
    end
    checkOutput("ack_latency", n, WS + 1);
    if (!v.we) checkOutput("read_data", dat_o, v.exp_rd);
    checkOutput("word0", word0, v.exp_w0);
    cyc = 1'b0; stb = 1'b0;
    tick();
    checkOutput("ack_single", ack, 1'b0);
    checkOutput("dat_after_ack", dat_o, 32'h0);
    tick();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int last, last0, nack;

    vecs[0] = '{1'b1, 32'h3000_0000, 32'h1111_1111, 4'hF, 32'h0,         32'h1111_1111};
    vecs[1] = '{1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF, 32'h0,         32'h1111_1111};
    vecs[2] = '{1'b0, 32'h3000_0004, 32'h0,         4'hF, 32'hDEAD_BEEF, 32'h1111_1111};
    vecs[3] = '{1'b1, 32'h3000_0004, 32'h0000_AA00, 4'h2, 32'h0,         32'h1111_1111};
    vecs[4] = '{1'b0, 32'h3000_0004, 32'h0,         4'h0, 32'hDEAD_AAEF, 32'h1111_1111};
    vecs[5] = '{1'b1, 32'h3000_0004, 32'h1234_5678, 4'h0, 32'h0,         32'h1111_1111};
    vecs[6] = '{1'b0, 32'h3000_0004, 32'h0,         4'hF, 32'hDEAD_AAEF, 32'h1111_1111};
    vecs[7] = '{1'b1, 32'h3000_003E, 32'hA5A5_A5A5, 4'h9, 32'h0,         32'h1111_1111};
    vecs[8] = '{1'b0, 32'h3000_003C, 32'h0,         4'hF, 32'hA500_00A5, 32'h1111_1111};
    vecs[9] = '{1'b0, 32'h3000_0001, 32'h0,         4'h3, 32'h1111_1111, 32'h1111_1111};

    nrst = 1'b0; en = 1'b1; adr = '0; dat = '0; sel = '0; we = 1'b0; stb = 1'b0; cyc = 1'b0;
    tick();
    tick();
    checkOutput("reset_ack", ack, 1'b0);
    checkOutput("reset_dat", dat_o, 32'h0);
    checkOutput("reset_word0", word0, 32'h0);
    nrst = 1'b1;
    tick();

    $display("[TB] abort in WAIT");
    adr = 32'h3000_0000; dat = 32'h1111_1111; sel = 4'hF; we = 1'b1; cyc = 1'b1; stb = 1'b1;
    tick();
    cyc = 1'b0; stb = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("abort_no_ack", ack, 1'b0);
      checkOutput("abort_word0", word0, 32'h0);
    end

    $display("[TB] vector table");
    for (int i = 0; i < 10; i++) applyStimulus(vecs[i]);

    $display("[TB] en low during WAIT");
    adr = 32'h3000_0008; dat = 32'h0BAD_F00D; sel = 4'hF; we = 1'b1; cyc = 1'b1; stb = 1'b1;
    tick();
    en = 1'b0;
    tick();
    checkOutput("en_low_wait_ack", ack, 1'b1);
    cyc = 1'b0; stb = 1'b0; en = 1'b1;
    tick();
    tick();
    applyStimulus('{1'b0, 32'h3000_0008, 32'h0, 4'hF, 32'h0BAD_F00D, 32'h1111_1111});

    $display("[TB] out-of-window read");
    adr = 32'h3000_0040; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checkOutput("oow_ack", ack, 1'b0);
      checkOutput("oow_dat", dat_o, 32'h0);
    end
    cyc = 1'b0; stb = 1'b0;
    tick();
    tick();

    $display("[TB] back-to-back reads");
    adr = 32'h3000_0004; we = 1'b0; cyc = 1'b1; stb = 1'b1;
    last = -1; last0 = -1; nack = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ack) begin
        nack++;
        checkOutput("b2b_data", dat_o, 32'hDEAD_AAEF);
        if (last >= 0) checkOutput("b2b_spacing_ws1", i - last, 4);
        last = i;
      end else begin
        checkOutput("b2b_dat_idle", dat_o, 32'h0);
      end
      if (ack0) begin
        if (last0 >= 0) checkOutput("b2b_spacing_ws0", i - last0, 3);
        last0 = i;
      end
    end
    checkOutput("b2b_ack_count", nack, 5);
    cyc = 1'b0; stb = 1'b0;
    tick();
    tick();

    $display("[TB] reset mid-WAIT");
    adr = 32'h3000_0008; dat = 32'h5555_5555; sel = 4'hF; we = 1'b1; cyc = 1'b1; stb = 1'b1;
    tick();
    #2 nrst = 1'b0;
    #1;
    checkOutput("rst_wait_ack", ack, 1'b0);
    checkOutput("rst_wait_word0", word0, 32'h0);
    cyc = 1'b0; stb = 1'b0;
    #1 nrst = 1'b1;
    tick();
    applyStimulus('{1'b0, 32'h3000_0008, 32'h0, 4'hF, 32'h0, 32'h0});
    applyStimulus('{1'b0, 32'h3000_0004, 32'h0, 4'hF, 32'h0, 32'h0});

    $display("[TB] reset during ACK");
    applyStimulus('{1'b1, 32'h3000_000C, 32'h7777_7777, 4'hF, 32'h0, 32'h0});
    adr = 32'h3000_000C; we = 1'b0; cyc = 1'b1; stb = 1'b1;
    tick();
    tick();
    checkOutput("pre_rst_ack", ack, 1'b1);
    checkOutput("pre_rst_dat", dat_o, 32'h7777_7777);
    #2 nrst = 1'b0;
    #1;
    checkOutput("rst_ack_async", ack, 1'b0);
    checkOutput("rst_dat_async", dat_o, 32'h0);
    cyc = 1'b0; stb = 1'b0;
    #1 nrst = 1'b1;
    tick();

    $display("[TB] en low blocks accept");
    en = 1'b0;
    adr = 32'h3000_0000; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("en_low_no_ack", ack, 1'b0);
    end
    en = 1'b1;
    tick();
    checkOutput("en_high_accept", ack, 1'b0);
    tick();
    checkOutput("en_high_ack", ack, 1'b1);
    checkOutput("en_high_data", dat_o, 32'h0);
    cyc = 1'b0; stb = 1'b0;
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
